regfile_wb_arbiter: RTL



---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_slot.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, request record and port identifiers for the register-file
// write-back arbiter.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int SEL_W  = $clog2(NREG);

  typedef struct packed {
    logic              valid;
    logic [SEL_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {WB_ALU, WB_MEM} wb_port_e;

  function automatic logic [NREG-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry request buffer for a single write-back producer; it can be drained
// and refilled on the same edge so a port sustains one write per cycle.
module wb_slot
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [SEL_W-1:0]  rd,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              ready,
  output wb_req_t           slot
);

  assign ready = !slot.valid || grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (valid && ready) begin
      slot <= '{valid: 1'b1, rd: rd, data: data};
    end else if (grant) begin
      slot.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter between the ALU and load path, driving the
// register file demux select/data and a one-hot write enable.
module regfile_wb_arbiter
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [SEL_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [SEL_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_hold,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREG-1:0]   wr_en,
  output logic [NREG-1:0]   pend_mask
);

  wb_req_t  alu_slot;
  wb_req_t  mem_slot;
  wb_port_e last_grant;
  logic     grant_alu;
  logic     grant_mem;

  wb_slot u_alu_slot (
    .clk   (clk),
    .rst   (rst),
    .valid (alu_valid),
    .rd    (alu_rd),
    .data  (alu_data),
    .grant (grant_alu),
    .ready (alu_ready),
    .slot  (alu_slot)
  );

  wb_slot u_mem_slot (
    .clk   (clk),
    .rst   (rst),
    .valid (mem_valid),
    .rd    (mem_rd),
    .data  (mem_data),
    .grant (grant_mem),
    .ready (mem_ready),
    .slot  (mem_slot)
  );

  // On a conflict the port that did not win last time gets the grant.
  assign grant_alu = !wr_hold && alu_slot.valid && (!mem_slot.valid || last_grant == WB_MEM);
  assign grant_mem = !wr_hold && mem_slot.valid && (!alu_slot.valid || last_grant == WB_ALU);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel     <= '0;
      wr_data    <= '0;
      wr_en      <= '0;
      last_grant <= WB_ALU;
    end else if (grant_alu) begin
      wr_sel     <= alu_slot.rd;
      wr_data    <= alu_slot.data;
      wr_en      <= onehot(alu_slot.rd);
      last_grant <= WB_ALU;
    end else if (grant_mem) begin
      wr_sel     <= mem_slot.rd;
      wr_data    <= mem_slot.data;
      wr_en      <= onehot(mem_slot.rd);
      last_grant <= WB_MEM;
    end else begin
      wr_en <= '0;
    end
  end

  // Covers both buffered requests and the write currently on the demux.
  assign pend_mask = (alu_slot.valid ? onehot(alu_slot.rd) : '0)
                   | (mem_slot.valid ? onehot(mem_slot.rd) : '0)
                   | wr_en;

endmodule
